// File: rtl/wishbone_uart_tx_arbiter.sv
// wishbone_uart_tx_arbiter: round-robin Wishbone master feeding NUM_REQ byte producers into one UART TX register.
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   req_valid/req_data        per-requester byte handshake in (byte i at [8i+7:8i])
//   req_ready                 one-cycle accept pulse to the granted requester
//   grant                     one-hot current owner, zero when idle
//   m_wb_*                    Wishbone master port (status read, then TX data write)
//   busy                      FSM not idle
//   err                       one-cycle pulse on ack watchdog abort
// Optional feature: define WB_UART_ARB_TIMEOUT_EN to enable the ack watchdog (TIMEOUT_CYCLES).
module wishbone_uart_tx_arbiter #(
    parameter int                    NUM_REQ         = 4,
    parameter int                    ADDR_WIDTH      = 16,
    parameter logic [ADDR_WIDTH-1:0] TX_REG_ADDR     = 'h4,
    parameter logic [ADDR_WIDTH-1:0] STATUS_REG_ADDR = 'h8,
    parameter int                    TX_FULL_BIT     = 3,
    parameter int                    TIMEOUT_CYCLES  = 255
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*8-1:0]    req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [NUM_REQ-1:0]      grant,
    output logic                    m_wb_cyc,
    output logic                    m_wb_stb,
    output logic                    m_wb_we,
    output logic [ADDR_WIDTH-1:0]   m_wb_addr,
    output logic [31:0]             m_wb_data_o,
    output logic [3:0]              m_wb_sel,
    input  logic                    m_wb_ack,
    input  logic [31:0]             m_wb_data_i,
    output logic                    busy,
    output logic                    err
);
    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [2:0] {IDLE, STAT, CHECK, GAP, WRITE, DONE} state_t;

    state_t                state, state_d;
    logic [IW-1:0]         last, last_d, idx, idx_d, pick, cand;
    logic [7:0]            tx_byte, tx_byte_d, pick_byte;
    logic                  full, full_d, found, timeout;
    logic                  cyc_d, stb_d, we_d, busy_d, err_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [31:0]           data_d;
    logic [3:0]            sel_d;
    logic [NUM_REQ-1:0]    grant_d, ready_d;

`ifdef WB_UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    // stb is low on every STAT/WRITE entry, so clearing on !stb restarts the count per phase.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) cnt <= '0;
        else       cnt <= (m_wb_stb && !m_wb_ack) ? cnt + 1'b1 : '0;
    end
    assign timeout = m_wb_stb && !m_wb_ack && cnt == CW'(TIMEOUT_CYCLES - 1);
`else
    // Watchdog absent: constant low, parameter kept so both builds share one interface.
    assign timeout = TIMEOUT_CYCLES < 0;
`endif

    // First valid requester after the last one served, wrapping around.
    always_comb begin
        pick  = last;
        cand  = '0;
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IW'((int'(last) + i) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        pick_byte = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (IW'(i) == pick) pick_byte = req_data[i*8 +: 8];
    end

    always_comb begin
        state_d   = state;
        last_d    = last;
        idx_d     = idx;
        tx_byte_d = tx_byte;
        full_d    = full;
        cyc_d     = m_wb_cyc;
        stb_d     = m_wb_stb;
        we_d      = m_wb_we;
        addr_d    = m_wb_addr;
        data_d    = m_wb_data_o;
        grant_d   = grant;
        ready_d   = '0;
        err_d     = 1'b0;
        case (state)
            IDLE: if (|req_valid) begin
                state_d   = STAT;
                idx_d     = pick;
                tx_byte_d = pick_byte;
                grant_d   = NUM_REQ'(1) << pick;
            end
            STAT: begin
                {cyc_d, stb_d, we_d} = 3'b110;
                addr_d = STATUS_REG_ADDR;
                if (m_wb_stb && m_wb_ack) begin
                    {cyc_d, stb_d} = 2'b00;
                    full_d  = |(m_wb_data_i & (32'd1 << TX_FULL_BIT));
                    state_d = CHECK;
                end else if (timeout) begin
                    {cyc_d, stb_d} = 2'b00;
                    err_d   = 1'b1;
                    ready_d = grant;
                    state_d = DONE;
                end
            end
            CHECK: state_d = full ? GAP : WRITE;
            GAP:   state_d = STAT;
            WRITE: begin
                {cyc_d, stb_d, we_d} = 3'b111;
                addr_d = TX_REG_ADDR;
                data_d = {24'h0, tx_byte};
                if ((m_wb_stb && m_wb_ack) || timeout) begin
                    {cyc_d, stb_d, we_d} = 3'b000;
                    err_d   = !(m_wb_stb && m_wb_ack);
                    ready_d = grant;
                    state_d = DONE;
                end
            end
            DONE: begin
                grant_d = '0;
                last_d  = idx;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        sel_d  = cyc_d ? 4'hF : 4'h0;
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            last        <= IW'(NUM_REQ - 1);
            idx         <= '0;
            tx_byte     <= '0;
            full        <= 1'b0;
            grant       <= '0;
            req_ready   <= '0;
            m_wb_cyc    <= 1'b0;
            m_wb_stb    <= 1'b0;
            m_wb_we     <= 1'b0;
            m_wb_addr   <= '0;
            m_wb_data_o <= '0;
            m_wb_sel    <= '0;
            busy        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_d;
            last        <= last_d;
            idx         <= idx_d;
            tx_byte     <= tx_byte_d;
            full        <= full_d;
            grant       <= grant_d;
            req_ready   <= ready_d;
            m_wb_cyc    <= cyc_d;
            m_wb_stb    <= stb_d;
            m_wb_we     <= we_d;
            m_wb_addr   <= addr_d;
            m_wb_data_o <= data_d;
            m_wb_sel    <= sel_d;
            busy        <= busy_d;
            err         <= err_d;
        end
    end
endmodule

// File: tb/tb_wishbone_uart_tx_arbiter.sv
// tb_wishbone_uart_tx_arbiter: scoreboard bench for the round-robin Wishbone UART TX arbiter.
`timescale 1ns/1ps
module tb_wishbone_uart_tx_arbiter;
    localparam int N = 4;

    typedef struct {
        int         idx;
        logic [7:0] b;
    } item_t;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*8-1:0] req_data = '0;
    logic [N-1:0]   req_ready, grant;
    logic           m_wb_cyc, m_wb_stb, m_wb_we, m_wb_ack, busy, err;
    logic [15:0]    m_wb_addr;
    logic [31:0]    m_wb_data_o, m_wb_data_i;
    logic [3:0]     m_wb_sel;

    item_t sbq[$];
    int    rdq[$];
    int    checks = 0, errors = 0;
    int    rd_acks = 0, wr_acks = 0, full_limit = 0;
    logic  rd_hold = 1'b0, wr_hold = 1'b0;
    int    ready_cnt = 0, busy_cnt = 0, cyclow_cnt = 0, stb_cnt = 0;
    int    err_cnt = 0, err_ready_cnt = 0, grant_bad = 0;
    logic  watch = 1'b0;
    logic [N-1:0] exp_grant = '0;
    item_t it;
    int    e;

    wishbone_uart_tx_arbiter dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready), .grant(grant),
        .m_wb_cyc(m_wb_cyc), .m_wb_stb(m_wb_stb), .m_wb_we(m_wb_we),
        .m_wb_addr(m_wb_addr), .m_wb_data_o(m_wb_data_o), .m_wb_sel(m_wb_sel),
        .m_wb_ack(m_wb_ack), .m_wb_data_i(m_wb_data_i),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Slave with ack latency 1; status reports full until full_limit reads have been acked.
    assign m_wb_ack    = m_wb_cyc && m_wb_stb && !(m_wb_we ? wr_hold : rd_hold);
    assign m_wb_data_i = (rd_acks < full_limit) ? 32'hFFFF_FFFF : 32'hFFFF_FFF7;

    always @(posedge clk)
        if (m_wb_cyc && m_wb_stb && m_wb_ack) begin
            if (m_wb_we) wr_acks <= wr_acks + 1;
            else         rd_acks <= rd_acks + 1;
        end

    always @(negedge clk) if (rstn) begin
        if (busy) busy_cnt++;
        if (busy && !m_wb_cyc) cyclow_cnt++;
        if (m_wb_stb) stb_cnt++;
        if (err) err_cnt++;
        if (err && |req_ready) err_ready_cnt++;
        if (watch && busy && grant !== exp_grant) grant_bad++;
        if (|grant) begin
            checks++;
            if ($countones(grant) > 1) begin
                errors++;
                $display("FAIL grant_onehot: grant=%b", grant);
            end
        end
        if (m_wb_cyc && m_wb_stb && m_wb_ack) begin
            checks++;
            if (m_wb_we) begin
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL write_unexpected: data=%h", m_wb_data_o);
                end else begin
                    it = sbq.pop_front();
                    if (m_wb_addr !== 16'h4 || m_wb_data_o !== {24'h0, it.b} || m_wb_sel !== 4'hF ||
                        grant !== (N'(1) << it.idx)) begin
                        errors++;
                        $display("FAIL wb_write: addr=%h data=%h sel=%h grant=%b, expected addr=0004 data=%h sel=f grant=%b",
                                 m_wb_addr, m_wb_data_o, m_wb_sel, grant, {24'h0, it.b}, N'(1) << it.idx);
                    end
                end
            end else if (m_wb_addr !== 16'h8 || m_wb_sel !== 4'hF) begin
                errors++;
                $display("FAIL wb_status_read: addr=%h sel=%h, expected addr=0008 sel=f", m_wb_addr, m_wb_sel);
            end
        end
        if (|req_ready) begin
            ready_cnt++;
            checks++;
            if (rdq.size() == 0) begin
                errors++;
                $display("FAIL ready_unexpected: req_ready=%b", req_ready);
            end else begin
                e = rdq.pop_front();
                if (req_ready !== (N'(1) << e) || grant !== req_ready) begin
                    errors++;
                    $display("FAIL ready: req_ready=%b grant=%b, expected both %b", req_ready, grant, N'(1) << e);
                end
            end
        end
    end

    task automatic expect_xfer(input int i, input logic [7:0] b, input bit written);
        if (written) sbq.push_back('{idx: i, b: b});
        rdq.push_back(i);
    endtask

    // Waits for n ready pulses; each requester drops valid after its ready unless keep is set.
    task automatic serve(input int n, input int budget, input bit keep, output int got, output int cyc);
        logic [N-1:0] drop;
        got = 0;
        cyc = 0;
        while (got < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            drop = req_ready;
            if (|drop) got++;
            @(posedge clk);
            #1;
            if (!keep) req_valid = req_valid & ~drop;
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({m_wb_cyc, m_wb_stb, m_wb_we, m_wb_addr, m_wb_data_o, m_wb_sel} !== '0) begin
            errors++;
            $display("FAIL reset_bus: cyc=%b stb=%b we=%b addr=%h data=%h sel=%h, expected all 0",
                     m_wb_cyc, m_wb_stb, m_wb_we, m_wb_addr, m_wb_data_o, m_wb_sel);
        end
        checks++;
        if ({grant, req_ready, busy, err} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: grant=%b ready=%b busy=%b err=%b, expected all 0", grant, req_ready, busy, err);
        end
        rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || m_wb_cyc !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b cyc=%b, expected 0 0", busy, m_wb_cyc);
        end
    endtask

    task automatic test_single();
        int got, c, r0, w0;
        @(posedge clk);
        #1;
        r0 = rd_acks;
        w0 = wr_acks;
        req_data[15:8] = 8'h5A;
        expect_xfer(1, 8'h5A, 1'b1);
        req_valid = 4'b0010;
        serve(1, 50, 1'b0, got, c);
        checks++;
        if (got != 1 || c != 7) begin
            errors++;
            $display("FAIL single_latency: readies=%0d ready_cycle=%0d, expected 1 and 7", got, c);
        end
        checks++;
        if (rd_acks - r0 != 1 || wr_acks - w0 != 1) begin
            errors++;
            $display("FAIL single_bus_count: reads=%0d writes=%0d, expected 1 1", rd_acks - r0, wr_acks - w0);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || grant !== '0 || sbq.size() != 0 || rdq.size() != 0) begin
            errors++;
            $display("FAIL single_end: busy=%b grant=%b pending=%0d/%0d, expected 0 0 0/0", busy, grant, sbq.size(), rdq.size());
        end
    endtask

    task automatic test_round_robin();
        int got, c;
        do_reset();
        req_data = 32'h4433_2211;
        expect_xfer(0, 8'h11, 1'b1);
        expect_xfer(1, 8'h22, 1'b1);
        expect_xfer(2, 8'h33, 1'b1);
        expect_xfer(3, 8'h44, 1'b1);
        expect_xfer(0, 8'h11, 1'b1);
        req_valid = 4'hF;
        serve(5, 200, 1'b1, got, c);
        req_valid = '0;
        checks++;
        if (got != 5 || c != 35) begin
            errors++;
            $display("FAIL rr_back_to_back: readies=%0d last_ready_cycle=%0d, expected 5 and 35", got, c);
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || sbq.size() != 0 || rdq.size() != 0) begin
            errors++;
            $display("FAIL rr_end: busy=%b pending=%0d/%0d, expected 0 0/0", busy, sbq.size(), rdq.size());
        end
    endtask

    task automatic test_full_retry();
        int got, c, r0, w0, b0, l0, g0;
        @(posedge clk);
        #1;
        r0 = rd_acks;
        w0 = wr_acks;
        b0 = busy_cnt;
        l0 = cyclow_cnt;
        g0 = grant_bad;
        full_limit = rd_acks + 3;
        exp_grant = 4'b1000;
        watch = 1'b1;
        req_data[31:24] = 8'hC3;
        expect_xfer(3, 8'hC3, 1'b1);
        req_valid = 4'b1000;
        serve(1, 200, 1'b0, got, c);
        watch = 1'b0;
        checks++;
        if (got != 1 || c != 19) begin
            errors++;
            $display("FAIL retry_latency: readies=%0d ready_cycle=%0d, expected 1 and 19", got, c);
        end
        checks++;
        if (rd_acks - r0 != 4 || wr_acks - w0 != 1) begin
            errors++;
            $display("FAIL retry_bus_count: reads=%0d writes=%0d, expected 4 1", rd_acks - r0, wr_acks - w0);
        end
        checks++;
        if (busy_cnt - b0 != 18 || cyclow_cnt - l0 != 13) begin
            errors++;
            $display("FAIL retry_cycles: busy=%0d cyc_low=%0d, expected 18 13", busy_cnt - b0, cyclow_cnt - l0);
        end
        checks++;
        if (grant_bad != g0) begin
            errors++;
            $display("FAIL retry_grant_hold: %0d busy cycles with grant != 1000, expected 0", grant_bad - g0);
        end
    endtask

    task automatic test_reset_mid_write();
        int got, c, r0;
        bit seen;
        req_data[7:0] = 8'h10;
        expect_xfer(0, 8'h10, 1'b1);
        req_valid = 4'b0001;
        serve(1, 50, 1'b0, got, c);
        wr_hold = 1'b1;
        req_data[23:16] = 8'h77;
        req_valid = 4'b0100;
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            seen = m_wb_we && m_wb_stb;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL midwrite_reach: write phase seen=%b, expected 1", seen);
        end
        repeat (3) @(negedge clk);
        r0 = ready_cnt;
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({m_wb_cyc, m_wb_stb, grant, busy} !== '0) begin
            errors++;
            $display("FAIL async_reset: cyc=%b stb=%b grant=%b busy=%b, expected all 0", m_wb_cyc, m_wb_stb, grant, busy);
        end
        @(posedge clk);
        #1;
        wr_hold = 1'b0;
        req_valid = 4'b0101;
        expect_xfer(0, 8'h10, 1'b1);
        expect_xfer(2, 8'h77, 1'b1);
        rstn = 1'b1;
        checks++;
        if (ready_cnt != r0) begin
            errors++;
            $display("FAIL reset_no_ready: %0d readies during reset, expected 0", ready_cnt - r0);
        end
        serve(2, 100, 1'b0, got, c);
        checks++;
        if (got != 2 || sbq.size() != 0 || rdq.size() != 0) begin
            errors++;
            $display("FAIL post_reset_order: readies=%0d pending=%0d/%0d, expected 2 0/0", got, sbq.size(), rdq.size());
        end
    endtask

    task automatic test_drop_valid();
        int got, c, n0;
        n0 = ready_cnt;
        req_data[23:16] = 8'hA5;
        expect_xfer(2, 8'hA5, 1'b1);
        req_valid = 4'b0100;
        @(posedge clk);
        #1;
        checks++;
        if (grant !== 4'b0100) begin
            errors++;
            $display("FAIL drop_grant: grant=%b, expected 0100", grant);
        end
        req_valid = '0;
        serve(1, 50, 1'b0, got, c);
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (got != 1 || ready_cnt - n0 != 1 || sbq.size() != 0 || rdq.size() != 0) begin
            errors++;
            $display("FAIL drop_valid: readies=%0d total=%0d pending=%0d/%0d, expected 1 1 0/0",
                     got, ready_cnt - n0, sbq.size(), rdq.size());
        end
    endtask

`ifdef WB_UART_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int got, c, s0, e0, x0, r0, w0;
        s0 = stb_cnt;
        e0 = err_cnt;
        x0 = err_ready_cnt;
        r0 = rd_acks;
        w0 = wr_acks;
        rd_hold = 1'b1;
        req_data[15:8] = 8'h99;
        expect_xfer(1, 8'h99, 1'b0);
        req_valid = 4'b0010;
        serve(1, 400, 1'b0, got, c);
        rd_hold = 1'b0;
        checks++;
        if (got != 1 || stb_cnt - s0 != 255) begin
            errors++;
            $display("FAIL timeout_stb: readies=%0d stb_cycles=%0d, expected 1 255", got, stb_cnt - s0);
        end
        checks++;
        if (err_cnt - e0 != 1 || err_ready_cnt - x0 != 1 || rd_acks != r0 || wr_acks != w0) begin
            errors++;
            $display("FAIL timeout_err: err=%0d err_with_ready=%0d acks=%0d/%0d, expected 1 1 0/0",
                     err_cnt - e0, err_ready_cnt - x0, rd_acks - r0, wr_acks - w0);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || rdq.size() != 0) begin
            errors++;
            $display("FAIL timeout_idle: busy=%b pending=%0d, expected 0 0", busy, rdq.size());
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_full_retry();
        test_reset_mid_write();
        test_drop_valid();
`ifdef WB_UART_ARB_TIMEOUT_EN
        test_timeout();
`else
        checks++;
        if (err_cnt != 0) begin
            errors++;
            $display("FAIL err_tied_low: %0d err pulses, expected 0", err_cnt);
        end
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
